// File: rtl/mstr_i2c.sv
// Single-master I2C controller: one-byte register write, or register read via repeated START.
// Every SCL bit is four quarter-periods (Q0..Q3) derived from the system clock.
module mstr_i2c #(
    parameter int FPGA_CLK = 50_000_000,
    parameter int I2C_CLK  = 100_000,
    parameter int DATA_SZ  = 8
) (
    input  logic               CLK,
    input  logic               RST_n,
    input  logic               I_START,
    input  logic [DATA_SZ-2:0] I_ADDR_SLV,
    input  logic               I_RW,
    input  logic [DATA_SZ-1:0] I_ADDR_REG,
    input  logic [DATA_SZ-1:0] I_DATA_WR,
    output logic               O_BUSY,
    output logic               O_DONE,
    output logic [DATA_SZ-1:0] O_DATA_RD,
    output logic               O_ACK_ERR,
    inout  wire                IO_SCL,
    inout  wire                IO_SDA
);
    localparam int QTR = FPGA_CLK / (4 * I2C_CLK);
    localparam int CW  = (QTR > 1) ? $clog2(QTR) : 1;

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ACK_ADDR, REG, ACK_REG, WDATA, ACK_WDATA,
        RSTART, ADDR_RD, ACK_ADDR_RD, RDATA, MACK, STOP
    } state_t;

    state_t             state_q, nst_d;
    logic [CW-1:0]      cnt_q;
    logic [1:0]         qtr_q;
    logic [2:0]         bit_q, nbit_d;
    logic [DATA_SZ-2:0] addr_q;
    logic               rw_q;
    logic [DATA_SZ-1:0] reg_q, wd_q, rsh_q, drd_q, txb_d;
    logic               scl_q, sda_q, samp_q, busy_q, done_q, ackerr_q, nsda_d;
    logic               tick, accept, is_ack;

    // scl_q/sda_q = 1 means released (open drain)
    assign IO_SCL    = scl_q ? 1'bz : 1'b0;
    assign IO_SDA    = sda_q ? 1'bz : 1'b0;
    assign O_BUSY    = busy_q;
    assign O_DONE    = done_q;
    assign O_DATA_RD = drd_q;
    assign O_ACK_ERR = ackerr_q;

    assign tick   = busy_q && (cnt_q == CW'(QTR - 1));
    assign accept = (state_q == IDLE) && !busy_q && I_START;
    assign is_ack = state_q inside {ACK_ADDR, ACK_REG, ACK_WDATA, ACK_ADDR_RD};

    // Transition taken at the end of Q3, plus the SDA level for the next bit's Q0
    always_comb begin
        nst_d  = state_q;
        nbit_d = bit_q;
        txb_d  = '0;
        case (state_q)
            START:       nst_d = ADDR;
            ADDR:        begin nbit_d = bit_q + 3'd1; if (&bit_q) nst_d = ACK_ADDR; end
            ACK_ADDR:    nst_d = samp_q ? STOP : REG;
            REG:         begin nbit_d = bit_q + 3'd1; if (&bit_q) nst_d = ACK_REG; end
            ACK_REG:     nst_d = samp_q ? STOP : (rw_q ? RSTART : WDATA);
            WDATA:       begin nbit_d = bit_q + 3'd1; if (&bit_q) nst_d = ACK_WDATA; end
            ACK_WDATA:   nst_d = STOP;
            RSTART:      nst_d = ADDR_RD;
            ADDR_RD:     begin nbit_d = bit_q + 3'd1; if (&bit_q) nst_d = ACK_ADDR_RD; end
            ACK_ADDR_RD: nst_d = samp_q ? STOP : RDATA;
            RDATA:       begin nbit_d = bit_q + 3'd1; if (&bit_q) nst_d = MACK; end
            MACK:        nst_d = STOP;
            STOP:        nst_d = IDLE;
            default:     nst_d = IDLE;
        endcase
        case (nst_d)
            ADDR:    txb_d = {addr_q, 1'b0};
            REG:     txb_d = reg_q;
            WDATA:   txb_d = wd_q;
            ADDR_RD: txb_d = {addr_q, 1'b1};
            default: txb_d = '0;
        endcase
        if (nst_d == STOP)
            nsda_d = 1'b0;
        else if (nst_d inside {ADDR, REG, WDATA, ADDR_RD})
            nsda_d = txb_d[3'd7 - nbit_d];
        else
            nsda_d = 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            qtr_q    <= '0;
            bit_q    <= '0;
            addr_q   <= '0;
            rw_q     <= 1'b0;
            reg_q    <= '0;
            wd_q     <= '0;
            rsh_q    <= '0;
            drd_q    <= '0;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
            samp_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ackerr_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (done_q) busy_q <= 1'b0;
            if (accept) begin
                addr_q   <= I_ADDR_SLV;
                rw_q     <= I_RW;
                reg_q    <= I_ADDR_REG;
                wd_q     <= I_DATA_WR;
                busy_q   <= 1'b1;
                ackerr_q <= 1'b0;
                cnt_q    <= '0;
                qtr_q    <= '0;
                bit_q    <= '0;
                state_q  <= START;
            end else if (busy_q) begin
                cnt_q <= tick ? '0 : cnt_q + CW'(1);
            end
            // Case label is the quarter just finishing; actions belong to the next one
            if (tick && state_q != IDLE) begin
                qtr_q <= qtr_q + 2'd1;
                case (qtr_q)
                    2'd0: if (state_q inside {RSTART, STOP}) scl_q <= 1'b1;
                    2'd1: begin
                        if (state_q inside {START, RSTART}) sda_q <= 1'b0;
                        else if (state_q != STOP)           scl_q <= 1'b1;
                    end
                    2'd2: begin
                        samp_q <= IO_SDA;
                        if (state_q == RDATA) rsh_q <= {rsh_q[DATA_SZ-2:0], IO_SDA};
                        if (state_q == STOP)  sda_q <= 1'b1;
                    end
                    default: begin
                        state_q <= nst_d;
                        bit_q   <= nbit_d;
                        if (is_ack && samp_q) ackerr_q <= 1'b1;
                        if (state_q == RDATA && (&bit_q)) drd_q <= rsh_q;
                        if (nst_d == IDLE) begin
                            done_q <= 1'b1;
                        end else begin
                            scl_q <= 1'b0;
                            sda_q <= nsda_d;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mstr_i2c.sv
// Bench for mstr_i2c: a bus monitor decodes START/STOP/9-bit frames and a simple slave
// answers; every transaction is compared against the frame list expected for the request.
module tb_mstr_i2c;
    localparam int QTR = 5;

    logic       CLK = 1'b0, RST_n = 1'b0, I_START = 1'b0, I_RW = 1'b0;
    logic [6:0] I_ADDR_SLV = '0;
    logic [7:0] I_ADDR_REG = '0, I_DATA_WR = '0;
    logic       O_BUSY, O_DONE, O_ACK_ERR;
    logic [7:0] O_DATA_RD;
    wire        scl, sda;
    logic       sl_drv = 1'b0;

    assign sda = sl_drv ? 1'b0 : 1'bz;
    pullup (scl);
    pullup (sda);

    always #5 CLK = ~CLK;

    mstr_i2c #(.FPGA_CLK(2_000_000), .I2C_CLK(100_000), .DATA_SZ(8)) dut (
        .CLK(CLK), .RST_n(RST_n), .I_START(I_START), .I_ADDR_SLV(I_ADDR_SLV), .I_RW(I_RW),
        .I_ADDR_REG(I_ADDR_REG), .I_DATA_WR(I_DATA_WR), .O_BUSY(O_BUSY), .O_DONE(O_DONE),
        .O_DATA_RD(O_DATA_RD), .O_ACK_ERR(O_ACK_ERR), .IO_SCL(scl), .IO_SDA(sda)
    );

    // Written by the stimulus process only
    int         tests = 0, fails = 0, clr_tok = 0;
    logic       sl_ack_en = 1'b1;
    logic [7:0] sl_rdata = '0, exp_rd = '0;

    // Written by the monitor process only
    int         log_q[$];
    int         clr_seen = 0, cyc = 0, fbits = 0, pulses = 0, dones = 0, last_rise = 0;
    int         per_min = 0, per_max = 0, hi_min = 0, hi_max = 0;
    int         sl_ph = 0, sl_n = 0, sl_byte = 0;
    logic       busy_at_done = 1'b0, sawrise = 1'b0, lr_data = 1'b0, sl_rd = 1'b0, ack;
    logic       prev_scl = 1'b1, prev_sda = 1'b1;
    logic [8:0] frame = '0;

    // Monitor + slave: sl_ph 0 idle, 1 receiving, 2 driving ACK, 3 transmitting
    always @(negedge CLK) begin
        cyc++;
        if (clr_tok != clr_seen) begin
            clr_seen = clr_tok; log_q.delete(); pulses = 0; dones = 0; sawrise = 1'b0;
            busy_at_done = 1'b0; per_min = 1000000; per_max = 0; hi_min = 1000000; hi_max = 0;
        end
        if (O_DONE === 1'b1) begin dones++; busy_at_done = O_BUSY; end
        if (RST_n !== 1'b1) begin sl_ph = 0; sl_drv = 1'b0; end
        if (prev_scl === 1'b1 && scl === 1'b1 && prev_sda === 1'b1 && sda === 1'b0) begin
            log_q.push_back(-1); fbits = 0; lr_data = 1'b0;
            sl_ph = 1; sl_n = 0; sl_byte = 0; sl_drv = 1'b0;
        end else if (prev_scl === 1'b1 && scl === 1'b1 && prev_sda === 1'b0 && sda === 1'b1) begin
            log_q.push_back(-2); fbits = 0; lr_data = 1'b0; sl_ph = 0; sl_drv = 1'b0;
        end
        if (prev_scl === 1'b0 && scl === 1'b1) begin
            if (fbits > 0) begin
                if (cyc - last_rise < per_min) per_min = cyc - last_rise;
                if (cyc - last_rise > per_max) per_max = cyc - last_rise;
            end
            frame = {frame[7:0], sda}; fbits++; last_rise = cyc; lr_data = 1'b1; sawrise = 1'b1;
            if (sl_ph == 1 || sl_ph == 3) sl_n++;
            if (fbits == 9) begin log_q.push_back(32'(frame)); fbits = 0; end
        end
        if (prev_scl === 1'b1 && scl === 1'b0) begin
            if (sawrise) pulses++;
            if (lr_data) begin
                if (cyc - last_rise < hi_min) hi_min = cyc - last_rise;
                if (cyc - last_rise > hi_max) hi_max = cyc - last_rise;
            end
            lr_data = 1'b0;
            case (sl_ph)
                1: if (sl_n == 8) begin
                    sl_n = 0;
                    ack = (sl_byte == 0) ? sl_ack_en : 1'b1;
                    if (sl_byte == 0) sl_rd = frame[0];
                    sl_byte++;
                    if (ack) begin sl_drv = 1'b1; sl_ph = 2; end else sl_ph = 0;
                end
                2: begin
                    sl_drv = 1'b0;
                    if (sl_rd) begin sl_ph = 3; sl_n = 0; sl_drv = !sl_rdata[7]; end
                    else sl_ph = 1;
                end
                3: if (sl_n < 8) sl_drv = !sl_rdata[7 - sl_n];
                   else begin sl_drv = 1'b0; sl_ph = 0; end
                default: ;
            endcase
        end
        prev_scl = scl;
        prev_sda = sda;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic run_txn(input logic [6:0] a, input logic rw, input logic [7:0] r,
                           input logic [7:0] wd, input logic present, input logic [7:0] rd,
                           input bit poke);
        int exp_q[$];
        int n, nfr;
        sl_ack_en = present; sl_rdata = rd; clr_tok++;
        @(negedge CLK);
        I_ADDR_SLV = a; I_RW = rw; I_ADDR_REG = r; I_DATA_WR = wd; I_START = 1'b1;
        @(negedge CLK);
        // Scrambled inputs must not leak into the transaction already accepted
        I_START = 1'b0; I_ADDR_SLV = 7'($urandom); I_RW = ~rw;
        I_ADDR_REG = 8'($urandom); I_DATA_WR = 8'($urandom);
        chk("busy_after_accept", 32'(O_BUSY), 32'd1);
        n = 0;
        while (O_DONE !== 1'b1 && n < 4000) begin
            @(negedge CLK); n++;
            I_START = poke && (n == 300);
        end
        chk("done_within_budget", 32'(O_DONE), 32'd1);
        I_START = 1'b1;
        @(negedge CLK);
        I_START = 1'b0;
        chk("busy_drops_after_done", 32'(O_BUSY), 32'd0);
        repeat (2) @(negedge CLK);
        chk("start_in_done_ignored", 32'(O_BUSY), 32'd0);

        if (rw && present) exp_rd = rd;
        exp_q.push_back(-1);
        exp_q.push_back(32'({a, 1'b0, ~present}));
        if (present) begin
            exp_q.push_back(32'({r, 1'b0}));
            if (!rw) exp_q.push_back(32'({wd, 1'b0}));
            else begin
                exp_q.push_back(-1);
                exp_q.push_back(32'({a, 1'b1, 1'b0}));
                exp_q.push_back(32'({rd, 1'b1}));
            end
        end
        exp_q.push_back(-2);
        nfr = 0;
        foreach (exp_q[i]) if (exp_q[i] >= 0) nfr++;

        chk("event_count", 32'(log_q.size()), 32'(exp_q.size()));
        foreach (exp_q[i])
            chk($sformatf("bus_event%0d", i),
                (i < log_q.size()) ? 32'(log_q[i]) : 32'h7fff_ffff, 32'(exp_q[i]));
        chk("ack_err", 32'(O_ACK_ERR), 32'(!present));
        chk("data_rd", 32'(O_DATA_RD), 32'(exp_rd));
        chk("scl_pulses", 32'(pulses), 32'(9 * nfr + ((rw && present) ? 1 : 0)));
        chk("done_pulses", 32'(dones), 32'd1);
        chk("busy_at_done", 32'(busy_at_done), 32'd1);
        chk("bus_idle", 32'({scl, sda}), 32'b11);
    endtask

    initial begin
        int n;
        logic [6:0] ra;
        logic       rrw, rpr;
        repeat (3) @(negedge CLK);
        chk("rst_busy", 32'(O_BUSY), 32'd0);
        chk("rst_done", 32'(O_DONE), 32'd0);
        chk("rst_ack_err", 32'(O_ACK_ERR), 32'd0);
        chk("rst_data_rd", 32'(O_DATA_RD), 32'd0);
        chk("rst_bus", 32'({scl, sda}), 32'b11);
        RST_n = 1'b1;
        repeat (20) @(negedge CLK);
        chk("no_start_no_busy", 32'(O_BUSY), 32'd0);

        run_txn(7'h50, 1'b0, 8'h12, 8'hA5, 1'b1, 8'h00, 1'b0);
        chk("scl_period_min", 32'(per_min), 32'(4 * QTR));
        chk("scl_period_max", 32'(per_max), 32'(4 * QTR));
        chk("scl_high_min", 32'(hi_min), 32'(2 * QTR));
        chk("scl_high_max", 32'(hi_max), 32'(2 * QTR));
        run_txn(7'h50, 1'b1, 8'h03, 8'h00, 1'b1, 8'h3C, 1'b0);
        run_txn(7'h50, 1'b1, 8'h07, 8'h00, 1'b0, 8'hFF, 1'b0);
        run_txn(7'h50, 1'b0, 8'h44, 8'h5A, 1'b1, 8'h00, 1'b1);
        run_txn(7'h2B, 1'b1, 8'hF0, 8'h00, 1'b1, 8'hC3, 1'b1);

        for (int k = 0; k < 6; k++) begin
            ra  = 7'($urandom);
            rrw = 1'($urandom);
            rpr = ($urandom_range(0, 3) != 0);
            run_txn(ra, rrw, 8'($urandom), 8'($urandom), rpr, 8'($urandom), 1'b0);
        end

        // Reset in the middle of the write-data byte
        clr_tok++; sl_ack_en = 1'b1;
        @(negedge CLK);
        I_ADDR_SLV = 7'h50; I_RW = 1'b0; I_ADDR_REG = 8'h12; I_DATA_WR = 8'hA5; I_START = 1'b1;
        @(negedge CLK);
        I_START = 1'b0;
        n = 0;
        while (log_q.size() < 3 && n < 2000) begin @(negedge CLK); n++; end
        chk("wdata_reached", 32'(log_q.size()), 32'd3);
        repeat (3 * 4 * QTR) @(negedge CLK);
        RST_n = 1'b0;
        #1;
        chk("mid_rst_bus", 32'({scl, sda}), 32'b11);
        chk("mid_rst_busy", 32'(O_BUSY), 32'd0);
        chk("mid_rst_done", 32'(O_DONE), 32'd0);
        chk("mid_rst_data_rd", 32'(O_DATA_RD), 32'd0);
        exp_rd = '0;
        repeat (5) @(negedge CLK);
        RST_n = 1'b1;
        repeat (300) @(negedge CLK);
        chk("post_rst_no_done", 32'(dones), 32'd0);
        chk("post_rst_idle", 32'(O_BUSY), 32'd0);
        run_txn(7'h50, 1'b1, 8'h03, 8'h00, 1'b1, 8'h96, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mstr_i2c.md
MSTR_I2C -- requirements
Module: mstr_i2c

Interface
REQ-001 Parameter FPGA_CLK, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter I2C_CLK, default 100_000, SCL frequency in Hz.
REQ-003 Parameter DATA_SZ, default 8, data and register-address width.
REQ-004 The block SHALL have exactly one clock and an asynchronous, active-low reset, with these ports:
- CLK  in  1  system clock.
- RST_n  in  1  asynchronous reset, active low.
- I_START  in  1  one-cycle transaction request; sampled only in IDLE.
- I_ADDR_SLV  in  DATA_SZ-1  7-bit slave address.
- I_RW  in  1  0 = write, 1 = read.
- I_ADDR_REG  in  DATA_SZ  register address in the slave.
- I_DATA_WR  in  DATA_SZ  byte to write.
- O_BUSY  out  1  transaction in progress.
- O_DONE  out  1  one-cycle pulse at end of STOP.
- O_DATA_RD  out  DATA_SZ  byte read from the slave.
- O_ACK_ERR  out  1  slave NACK seen in the last transaction.
- IO_SCL  inout  1  open-drain SCL; drives 0 or z.
- IO_SDA  inout  1  open-drain SDA; drives 0 or z.

Function
REQ-005 All request inputs SHALL be latched in the cycle I_START is accepted; later input changes SHALL have no effect until the next IDLE.
REQ-006 A quarter-bit tick SHALL fire every QTR = FPGA_CLK/(4*I2C_CLK) CLK cycles (125 at defaults); the counter SHALL run only when O_BUSY=1 and SHALL restart at 0 on acceptance.
REQ-007 Each bit SHALL span quarters Q0..Q3:
- Q0, Q1: SCL low; SDA updated at the start of Q0.
- Q2, Q3: SCL released; SDA sampled at the start of Q3.
REQ-008 States: IDLE, START, ADDR, ACK_ADDR, REG, ACK_REG, WDATA, ACK_WDATA, RSTART, ADDR_RD, ACK_ADDR_RD, RDATA, MACK, STOP.
REQ-009 Write sequence: START, ADDR (addr,0), ACK_ADDR, REG, ACK_REG, WDATA, ACK_WDATA, STOP.
REQ-010 Read sequence: START, ADDR (addr,0), ACK_ADDR, REG, ACK_REG, RSTART, ADDR_RD (addr,1), ACK_ADDR_RD, RDATA, MACK (master NACK, SDA released), STOP.
REQ-011 START and RSTART SHALL drive SDA low while SCL is high for at least 2 quarters, then drive SCL low. RSTART SHALL first release SDA with SCL low, then release SCL.
REQ-012 STOP SHALL drive SDA low with SCL low, release SCL, and release SDA 2 quarters later.
REQ-013 Bytes SHALL be shifted MSB first; a 3-bit bit counter SHALL wrap from 7 to 0 at each ACK state.
REQ-014 In an ACK state SDA SHALL be released; SDA=1 sampled at Q3 SHALL set O_ACK_ERR and go directly to STOP, skipping remaining bytes.
REQ-015 O_DATA_RD SHALL update only when RDATA completes; a NACK-aborted read SHALL leave O_DATA_RD unchanged.
REQ-016 O_BUSY SHALL be 1 from the cycle after I_START acceptance through the O_DONE cycle inclusive.
REQ-017 O_DONE SHALL pulse for exactly one cycle, coincident with the return to IDLE.
REQ-018 O_ACK_ERR SHALL clear on acceptance of a new I_START.
REQ-019 I_START while O_BUSY=1 SHALL be ignored; I_START in the O_DONE cycle SHALL be ignored.
REQ-020 The block SHALL not support clock stretching or multi-master arbitration; SCL SHALL be generated purely from the tick.

Reset
REQ-021 When RST_n is asserted, including mid-transaction, the block SHALL immediately enter IDLE with IO_SCL=z, IO_SDA=z, O_BUSY=0, O_DONE=0, O_ACK_ERR=0, O_DATA_RD=0, and all counters 0.
REQ-022 After reset release, the first transaction SHALL require a fresh I_START.

Verification
REQ-023 Write: addr 0x50, reg 0x12, data 0xA5, slave ACKs all -> SDA bytes 0xA0, 0x12, 0xA5; STOP; O_DONE pulse; O_ACK_ERR=0.
REQ-024 Read: addr 0x50, reg 0x03, slave returns 0x3C -> bytes 0xA0, 0x03, repeated START, 0xA1; master NACK; O_DATA_RD=0x3C.
REQ-025 Address NACK: no slave present (SDA pulled up) -> STOP right after ACK_ADDR; O_ACK_ERR=1; O_DONE pulse; only 9 SCL pulses.
REQ-026 Timing: at defaults, SCL period = 500 CLK cycles (±1), 50% duty; SDA edges only while SCL is low, except at START/STOP.
REQ-027 Reset asserted mid-WDATA -> IO_SCL=z and IO_SDA=z in the same cycle; O_BUSY=0; no O_DONE pulse.
REQ-028 I_START pulsed while busy -> no effect; the current transaction completes unchanged.
